// File: rtl/bin2bcd_seq_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq_pkg
// Shared definitions for the sequential double-dabble binary-to-BCD converter:
// FSM state encoding, counter sizing and the per-nibble adjust constants.
// -----------------------------------------------------------------------------
package bin2bcd_seq_pkg;

    // Any encoding outside these three recovers to IDLE in the FSM.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        FINISH = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH  = 10;
    localparam int DEFAULT_DIGITS = 4;

    // Shift counter width for a given binary width (never narrower than 1 bit).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

    // A nibble at or above the threshold would exceed 9 after doubling,
    // so it is pre-corrected by the adjust value before the shift.
    localparam logic [3:0] NIBBLE_THRESH = 4'd5;
    localparam logic [3:0] NIBBLE_ADJUST = 4'd3;

endpackage : bin2bcd_seq_pkg

// File: rtl/bin2bcd_seq_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble nibble correction: dout = din>=5 ? din+3 : din.
// The result is kept to 4 bits; there is no carry between nibbles.
//
// Ports:
//   din   in  [3:0]  scratch nibble before correction
//   dout  out [3:0]  corrected nibble
// -----------------------------------------------------------------------------
module bcd_add3
    import bin2bcd_seq_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= NIBBLE_THRESH) ? din + NIBBLE_ADJUST : din;

endmodule : bcd_add3

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential shift-and-add-3 converter. A START in IDLE latches BIN; WIDTH
// shift cycles later the packed BCD result is written to D0..D3 and DONE
// pulses for one cycle. D0..D3 only change on completion (or reset), so the
// downstream 7-segment decoders never see intermediate scratch values.
//
// Ports:
//   clk    in              system clock, rising edge
//   rst_n  in              asynchronous active-low reset
//   start  in              conversion request, sampled only in IDLE
//   bin    in  [WIDTH-1:0] unsigned value, captured on the accepting edge
//   busy   out             high while shifting
//   done   out             one-cycle pulse, D0..D3 newly updated
//   d0     out [3:0]       units digit
//   d1     out [3:0]       tens digit
//   d2     out [3:0]       hundreds digit
//   d3     out [3:0]       thousands digit
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       d0,
    output logic [3:0]       d1,
    output logic [3:0]       d2,
    output logic [3:0]       d3
);

    localparam int             SW       = 4 * DIGITS;
    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q;
    logic [SW-1:0]    scr_q;
    logic [SW-1:0]    scr_adj;
    logic [SW-1:0]    scr_next;
    logic [CW-1:0]    cnt_q;
    logic             load;
    logic             shift_en;
    logic             last;
    logic             unused_scr_msb;

    // ------------------------------------------------------------------
    // Per-digit add-3 correction on the current scratch contents.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scr_q[4*g +: 4]),
            .dout (scr_adj[4*g +: 4])
        );
    end

    // Correct first, then shift {scratch, binreg} left by one. The top
    // corrected bit falls off; DIGITS is sized so it is always zero.
    assign scr_next       = {scr_adj[SW-2:0], bin_q[WIDTH-1]};
    assign unused_scr_msb = scr_adj[SW-1];

    // ------------------------------------------------------------------
    // FSM next-state and control decode.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case leaves a signal unassigned (no latches).
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        last     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    last    = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Datapath: binary shift register, BCD scratch and shift counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: scratch and counter are reset too, so an abandoned
        // conversion leaves no stale state visible after reset.
        if (!rst_n) begin
            bin_q <= '0;
            scr_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            bin_q <= bin;
            scr_q <= '0;
            cnt_q <= '0;
        end else if (shift_en) begin
            bin_q <= {bin_q[WIDTH-2:0], 1'b0};
            scr_q <= scr_next;
            cnt_q <= last ? '0 : cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs. Status flags are taken from the next state so
    // they line up with the state register; digits load only on the
    // final shift with the post-shift scratch value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            d0   <= '0;
            d1   <= '0;
            d2   <= '0;
            d3   <= '0;
        end else begin
            busy <= (state_d == SHIFT);
            done <= (state_d == FINISH);
            if (last) begin
                d0 <= scr_next[3:0];
                d1 <= scr_next[7:4];
                d2 <= scr_next[11:8];
                d3 <= scr_next[15:12];
            end
        end
    end

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
// Self-checking bench for bin2bcd_seq: fixed vector table, exhaustive and
// random sweeps against an arithmetic decimal-digit model, and hand-written
// sequences for START/BIN during conversion, asynchronous reset and
// back-to-back operation with START held high.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] bin   = '0;
    logic       busy, done;
    logic [3:0] d0, d1, d2, d3;
    logic [15:0] dout;

    int tests = 0;
    int fails = 0;

    bin2bcd_seq #(.WIDTH(10), .DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3)
    );

    assign dout = {d3, d2, d1, d0};

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [9:0]  bin;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by plain division, packed thousands..units.
    function automatic logic [15:0] model(input int v);
        logic [3:0] u, t, h, k;
        u = 4'(v % 10);
        t = 4'((v / 10) % 10);
        h = 4'((v / 100) % 10);
        k = 4'((v / 1000) % 10);
        return {k, h, t, u};
    endfunction

    // One conversion from IDLE: checks BUSY, latency, result capture and
    // that DONE lasts a single cycle. Returns the digits seen with DONE.
    task automatic run_conv(input logic [9:0] v, input string tag, output logic [15:0] res);
        int n;
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        #1 check({tag, " busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
        check({tag, " latency"}, n, 10);
        res = dout;
        @(posedge clk);
        #1 check({tag, " done width"}, 32'(done), 32'd0);
    endtask

    initial begin
        vec_t        vecs[6];
        logic [15:0] res;
        int          done_cnt, done_edge;
        int          done_edges[$];
        logic [9:0]  rv;

        vecs[0] = '{10'd0,    16'h0000};
        vecs[1] = '{10'd1023, 16'h1023};
        vecs[2] = '{10'd999,  16'h0999};
        vecs[3] = '{10'd640,  16'h0640};
        vecs[4] = '{10'd1,    16'h0001};
        vecs[5] = '{10'd512,  16'h0512};

        // Reset state
        #1;
        check("reset digits", 32'(dout), 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle digits", 32'(dout), 32'h0);
        check("idle busy", 32'(busy), 32'd0);
        check("idle done", 32'(done), 32'd0);

        // Fixed vector table
        for (int i = 0; i < 6; i++) begin
            run_conv(vecs[i].bin, "vec", res);
            check($sformatf("vec %0d", vecs[i].bin), 32'(res), 32'(vecs[i].exp));
        end

        // Exhaustive sweep
        for (int v = 0; v < 1024; v++) begin
            run_conv(10'(v), "sweep", res);
            check($sformatf("sweep %0d", v), 32'(res), 32'(model(v)));
        end

        // Random values with random idle gaps
        for (int i = 0; i < 200; i++) begin
            rv = 10'($urandom_range(0, 1023));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_conv(rv, "rand", res);
            check($sformatf("rand %0d", rv), 32'(res), 32'(model(int'(rv))));
        end

        // START pulses and BIN changes during SHIFT are ignored
        @(negedge clk);
        bin   = 10'd640;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        done_cnt  = 0;
        done_edge = 0;
        res       = '0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_cnt++;
                if (done_edge == 0) begin
                    done_edge = i;
                    res       = dout;
                end
            end
            @(negedge clk);
            if (i < 8) begin
                start = i[0];
                bin   = 10'd5;
            end else begin
                start = 1'b0;
            end
        end
        check("ignore done count", done_cnt, 1);
        check("ignore done edge", done_edge, 10);
        check("ignore result", 32'(res), 32'h0640);

        // Asynchronous reset mid-conversion
        run_conv(10'd42, "pre-reset", res);
        check("pre-reset result", 32'(res), 32'h0042);
        @(negedge clk);
        bin   = 10'd512;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset digits", 32'(dout), 32'h0);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("no done after reset", done_cnt, 0);
        check("digits after reset", 32'(dout), 32'h0);
        run_conv(10'd7, "post-reset", res);
        check("post-reset result", 32'(res), 32'h0007);

        // START held high: conversions every 12 cycles, results in order
        @(negedge clk);
        bin   = 10'd5;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bin = 10'd640;
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk);
            #1;
            if (done) done_edges.push_back(i);
            if (i == 10) check("held first result", 32'(dout), 32'h0005);
            if (i == 11) check("held idle gap busy", 32'(busy), 32'd0);
            if (i == 12) check("held restart busy", 32'(busy), 32'd1);
            if (i == 21) check("held digits stable", 32'(dout), 32'h0005);
            if (i == 22) check("held second result", 32'(dout), 32'h0640);
        end
        start = 1'b0;
        check("held done count", done_edges.size(), 2);
        if (done_edges.size() == 2) begin
            check("held done edge 1", done_edges[0], 10);
            check("held done edge 2", done_edges[1], 22);
        end
        repeat (15) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_bin2bcd_seq
